// File: rtl/combo_entry_controller.sv
// Combo lock PIN entry: button sync/edge detect, digit entry,
// code compare and LOCKED/ENTRY/CHECK/UNLOCKED/LOCKOUT sequencing.
module combo_entry_controller #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic        btn_lock,
  output logic [3:0]  digit_sel,
  output logic [15:0] entered,
  output logic [2:0]  digit_count,
  output logic [2:0]  state,
  output logic        unlocked,
  output logic        alarm
);

  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_INIT =
    TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0] T_MAX = 3'(MAX_TRIES);

  logic [4:0]    sync1_q, sync1_d;
  logic [4:0]    sync2_q, sync2_d;
  logic [4:0]    prev_q, prev_d;
  logic [4:0]    ev;
  logic [3:0]    sel_q, sel_d;
  logic [15:0]   ent_q, ent_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic [2:0]    tries_q, tries_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unl_q, unl_d;
  logic          alm_q, alm_d;

  logic ev_up, ev_down, ev_enter;
  logic ev_clear, ev_lock;

  assign ev_up    = ev[0];
  assign ev_down  = ev[1];
  assign ev_enter = ev[2];
  assign ev_clear = ev[3];
  assign ev_lock  = ev[4];

  always_comb begin
    sync1_d = {btn_lock, btn_clear, btn_enter,
               btn_down, btn_up};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    ev      = sync2_q & ~prev_q;

    sel_d   = sel_q;
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    tries_d = tries_q;
    timer_d = timer_q;

    unique case (state_q)
      S_LOCKED, S_ENTRY: begin
        if (ev_clear) begin
          ent_d   = '0;
          cnt_d   = '0;
          state_d = S_LOCKED;
        end else if (ev_lock) begin
          // lock outranks enter/up/down but does nothing here
          state_d = state_q;
        end else if (ev_enter) begin
          ent_d   = {ent_q[11:0], sel_q};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd3) ? S_CHECK : S_ENTRY;
        end else if (ev_up && !ev_down) begin
          sel_d = sel_q + 4'd1;
        end else if (ev_down && !ev_up) begin
          sel_d = sel_q - 4'd1;
        end
      end
      S_CHECK: begin
        ent_d = '0;
        cnt_d = '0;
        if (ent_q == CODE) begin
          state_d = S_UNLOCKED;
          tries_d = '0;
        end else if (tries_q + 3'd1 >= T_MAX) begin
          state_d = S_LOCKOUT;
          tries_d = T_MAX;
          timer_d = T_INIT;
        end else begin
          state_d = S_LOCKED;
          tries_d = tries_q + 3'd1;
        end
      end
      S_UNLOCKED: begin
        if (ev_lock) begin
          state_d = S_LOCKED;
          ent_d   = '0;
          cnt_d   = '0;
          sel_d   = '0;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
          tries_d = '0;
          sel_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_LOCKED;
      end
    endcase

    unl_d = (state_d == S_UNLOCKED);
    alm_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      sel_q   <= '0;
      ent_q   <= '0;
      cnt_q   <= '0;
      state_q <= S_LOCKED;
      tries_q <= '0;
      timer_q <= '0;
      unl_q   <= 1'b0;
      alm_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      sel_q   <= sel_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      unl_q   <= unl_d;
      alm_q   <= alm_d;
    end
  end

  assign digit_sel   = sel_q;
  assign entered     = ent_q;
  assign digit_count = cnt_q;
  assign state       = state_q;
  assign unlocked    = unl_q;
  assign alarm       = alm_q;

endmodule

// File: tb/tb_combo_entry_controller.sv
// Directed bench for combo_entry_controller
// with CODE=1234, MAX_TRIES=3, LOCKOUT_CYCLES=16.
module tb_combo_entry_controller;

  localparam logic [4:0] UP  = 5'b00001;
  localparam logic [4:0] DN  = 5'b00010;
  localparam logic [4:0] ENT = 5'b00100;
  localparam logic [4:0] CLR = 5'b01000;
  localparam logic [4:0] LCK = 5'b10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btns;
  logic [3:0]  digit_sel;
  logic [15:0] entered;
  logic [2:0]  digit_count;
  logic [2:0]  state;
  logic        unlocked;
  logic        alarm;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] exp_sel;

  combo_entry_controller #(
    .CODE(16'h1234),
    .MAX_TRIES(3),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btns[0]),
    .btn_down(btns[1]),
    .btn_enter(btns[2]),
    .btn_clear(btns[3]),
    .btn_lock(btns[4]),
    .digit_sel(digit_sel),
    .entered(entered),
    .digit_count(digit_count),
    .state(state),
    .unlocked(unlocked),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    btns = b;
    repeat (3) tick();
    btns = '0;
    repeat (3) tick();
  endtask

  task automatic goto_digit(input logic [3:0] d);
    while (exp_sel != d) begin
      press(UP);
      exp_sel = exp_sel + 4'd1;
    end
  endtask

  // leaves the 4th enter held with the DUT in CHECK
  task automatic enter_code(input logic [15:0] code);
    logic [3:0] dig;
    for (int i = 0; i < 3; i++) begin
      dig = code[4*(3-i) +: 4];
      goto_digit(dig);
      press(ENT);
    end
    dig = code[3:0];
    goto_digit(dig);
    btns = ENT;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btns = '0;
    repeat (2) tick();
    vectors++;
    if ({digit_sel, entered, digit_count, state,
         unlocked, alarm} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outs: got %h %h %h %h %b %b want all 0",
        digit_sel, entered, digit_count, state,
        unlocked, alarm);
    end
    rst = 1'b1;
    tick();
    exp_sel = 4'h0;
  endtask

  task automatic test_updown();
    btns = UP;
    tick();
    tick();
    vectors++;
    if (digit_sel !== 4'h0) begin
      errors++;
      $display("FAIL up_early: got %h want 0", digit_sel);
    end
    tick();
    vectors++;
    if (digit_sel !== 4'h1) begin
      errors++;
      $display("FAIL up_edge3: got %h want 1", digit_sel);
    end
    btns = '0;
    repeat (3) tick();
    press(DN);
    press(DN);
    vectors++;
    if (digit_sel !== 4'hF) begin
      errors++;
      $display("FAIL down_wrap: got %h want f", digit_sel);
    end
    press(UP | DN);
    vectors++;
    if (digit_sel !== 4'hF || state !== 3'd0) begin
      errors++;
      $display("FAIL up_dn_same: got %h/%0d want f/0",
        digit_sel, state);
    end
    exp_sel = 4'hF;
  endtask

  task automatic test_unlock();
    enter_code(16'h1234);
    vectors++;
    if (entered !== 16'h1234 || digit_count !== 3'd4 ||
        state !== 3'd2) begin
      errors++;
      $display("FAIL check_entry: got %h/%0d/%0d want 1234/4/2",
        entered, digit_count, state);
    end
    tick();
    btns = '0;
    vectors++;
    if (state !== 3'd3 || unlocked !== 1'b1 ||
        entered !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL unlock: got %0d/%b/%h/%0d want 3/1/0/0",
        state, unlocked, entered, digit_count);
    end
    repeat (3) tick();
    press(UP);
    vectors++;
    if (digit_sel !== 4'h4 || state !== 3'd3) begin
      errors++;
      $display("FAIL up_in_unlocked: got %h/%0d want 4/3",
        digit_sel, state);
    end
    press(LCK);
    vectors++;
    if (state !== 3'd0 || entered !== 16'h0 ||
        digit_sel !== 4'h0 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL relock: got %0d/%h/%h/%b want 0/0/0/0",
        state, entered, digit_sel, unlocked);
    end
    exp_sel = 4'h0;
  endtask

  task automatic test_lockout();
    int n;
    int bad_alarm;
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1235);
      vectors++;
      if (state !== 3'd2) begin
        errors++;
        $display("FAIL wrong_check%0d: got %0d want 2", k, state);
      end
      tick();
      btns = '0;
      if (k < 2) begin
        vectors++;
        if (state !== 3'd0 || alarm !== 1'b0) begin
          errors++;
          $display("FAIL wrong%0d: got %0d/%b want 0/0",
            k, state, alarm);
        end
        repeat (3) tick();
      end
    end
    vectors++;
    if (state !== 3'd4 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL lockout_enter: got %0d/%b want 4/1",
        state, alarm);
    end
    n = 0;
    bad_alarm = 0;
    while (state === 3'd4 && n < 40) begin
      n++;
      if (alarm !== 1'b1) bad_alarm++;
      if (n == 3) btns = UP | ENT;
      if (n == 8) btns = '0;
      tick();
    end
    btns = '0;
    vectors++;
    if (n != 16 || bad_alarm != 0) begin
      errors++;
      $display("FAIL lockout_len: got %0d cyc %0d lowalarm want 16 0",
        n, bad_alarm);
    end
    vectors++;
    if (state !== 3'd0 || alarm !== 1'b0 ||
        digit_sel !== 4'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL lockout_exit: got %0d/%b/%h/%0d want 0/0/0/0",
        state, alarm, digit_sel, digit_count);
    end
    exp_sel = 4'h0;
    repeat (3) tick();
    enter_code(16'h1235);
    tick();
    btns = '0;
    vectors++;
    if (state !== 3'd0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL tries_cleared: got %0d/%b want 0/0",
        state, alarm);
    end
    repeat (3) tick();
  endtask

  task automatic test_clear();
    goto_digit(4'h1);
    press(ENT);
    goto_digit(4'h2);
    press(ENT);
    vectors++;
    if (entered !== 16'h0012 || digit_count !== 3'd2 ||
        state !== 3'd1) begin
      errors++;
      $display("FAIL two_digits: got %h/%0d/%0d want 0012/2/1",
        entered, digit_count, state);
    end
    press(CLR);
    vectors++;
    if (entered !== 16'h0 || digit_count !== 3'd0 ||
        state !== 3'd0 || digit_sel !== 4'h2) begin
      errors++;
      $display("FAIL clear: got %h/%0d/%0d/%h want 0/0/0/2",
        entered, digit_count, state, digit_sel);
    end
    press(ENT);
    press(ENT | CLR);
    vectors++;
    if (entered !== 16'h0 || digit_count !== 3'd0 ||
        state !== 3'd0) begin
      errors++;
      $display("FAIL clear_wins: got %h/%0d/%0d want 0/0/0",
        entered, digit_count, state);
    end
  endtask

  task automatic test_hold();
    btns = ENT;
    repeat (50) tick();
    btns = '0;
    repeat (3) tick();
    vectors++;
    if (digit_count !== 3'd1 || entered !== 16'h0002 ||
        state !== 3'd1) begin
      errors++;
      $display("FAIL hold_enter: got %0d/%h/%0d want 1/0002/1",
        digit_count, entered, state);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    tick();
    vectors++;
    if ({digit_sel, entered, digit_count, state,
         unlocked, alarm} !== 28'd0) begin
      errors++;
      $display("FAIL rst_entry: got %h %h %h %h %b %b want all 0",
        digit_sel, entered, digit_count, state,
        unlocked, alarm);
    end
    rst = 1'b1;
    tick();
    exp_sel = 4'h0;
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1235);
      tick();
      btns = '0;
      repeat (3) tick();
    end
    vectors++;
    if (state !== 3'd4 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_lockout: got %0d/%b want 4/1",
        state, alarm);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({digit_sel, entered, digit_count, state,
         unlocked, alarm} !== 28'd0) begin
      errors++;
      $display("FAIL rst_lockout: got %h %h %h %h %b %b want all 0",
        digit_sel, entered, digit_count, state,
        unlocked, alarm);
    end
    rst = 1'b1;
    tick();
    exp_sel = 4'h0;
    enter_code(16'h1234);
    tick();
    btns = '0;
    vectors++;
    if (state !== 3'd3 || unlocked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_after_rst: got %0d/%b want 3/1",
        state, unlocked);
    end
    repeat (3) tick();
  endtask

  initial begin
    rst  = 1'b0;
    btns = '0;
    exp_sel = 4'h0;
    test_reset();
    test_updown();
    test_unlock();
    test_lockout();
    test_clear();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, errors);
    $finish;
  end

endmodule
